cpu_param: RTL

Parametrised second-generation accumulator CPU for the FPGA experiment SoC. It fetches instructions from a synchronous block RAM over separate read and write ports, and executes from a general register file through a parametrised ALU. It talks to the UART through valid/busy handshakes and supports a bounded hardware call/return stack. It sits between the program RAM, the UART TX/RX blocks and the top-level start/status logic.

---
 rtl/cpu_param_pkg.sv | 52 +++++
 rtl/cpu_param_if.sv | 33 +++
 rtl/cpu_param_alu.sv | 30 +++
 rtl/cpu_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_param_pkg.sv
// -----------------------------------------------------------------------------
// cpu_param_pkg
// Shared definitions for the cpu_param accumulator CPU: instruction function
// codes, FSM state encoding, flag bit positions and the register-index helper.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_param_pkg;

    // Instruction byte layout: [7] two-byte, [6:3] function, [1:0] register.
    localparam int OP_TWO_BIT = 7;

    // One-byte functions (op[7] = 0)
    localparam logic [3:0] F_HLT  = 4'h0;
    localparam logic [3:0] F_OUT  = 4'h1;
    localparam logic [3:0] F_IN   = 4'h2;
    localparam logic [3:0] F_ADD  = 4'h3;
    localparam logic [3:0] F_SUB  = 4'h4;
    localparam logic [3:0] F_RET  = 4'h5;

    // Two-byte functions (op[7] = 1)
    localparam logic [3:0] F_LDI  = 4'h0;
    localparam logic [3:0] F_LD   = 4'h1;
    localparam logic [3:0] F_ST   = 4'h2;
    localparam logic [3:0] F_BRA  = 4'h3;
    localparam logic [3:0] F_BRZ  = 4'h4;
    localparam logic [3:0] F_BRC  = 4'h5;
    localparam logic [3:0] F_CALL = 4'h6;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_OPLOAD,
        S_DECODE,
        S_WAIT2,
        S_OPLOAD2,
        S_EXEC2,
        S_WAIT3,
        S_MEMLOAD,
        S_TX,
        S_RX
    } state_t;

    // Register fields beyond the implemented register count fall back to r0.
    function automatic logic [1:0] reg_sel(input logic [1:0] r, input int nregs);
        return (int'(r) < nregs) ? r : 2'd0;
    endfunction

endpackage

// File: rtl/cpu_param_if.sv
// -----------------------------------------------------------------------------
// cpu_param_if
// Bus bundle between the CPU and its neighbours: program RAM read/write ports
// and the UART transmit/receive handshakes.
//   master : CPU side   (drives RAM address/write, tx_data/tx_valid)
//   slave  : RAM/UART side
// Parameters: DW data width, AW address width.
// -----------------------------------------------------------------------------
interface cpu_param_if #(
    parameter int DW = 8,
    parameter int AW = 9
);
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_busy;
    logic [DW-1:0] rx_data;
    logic          rx_valid;

    modport master (
        output mem_raddr, mem_waddr, mem_wdata, mem_we, tx_data, tx_valid,
        input  mem_rdata, tx_busy, rx_data, rx_valid
    );

    modport slave (
        input  mem_raddr, mem_waddr, mem_wdata, mem_we, tx_data, tx_valid,
        output mem_rdata, tx_busy, rx_data, rx_valid
    );
endinterface

// File: rtl/cpu_param_alu.sv
// -----------------------------------------------------------------------------
// cpu_param_alu
// DW-wide adder/subtractor for the accumulator.
//   a, b    in  operands (a is the accumulator)
//   sub     in  1 = a - b, 0 = a + b
//   result  out DW-bit result
//   carry   out carry-out on add, borrow on subtract
//   zero    out result == 0
// -----------------------------------------------------------------------------
module cpu_param_alu #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          sub,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);
    logic [DW:0] sum;

    // The extra top bit of a zero-extended difference is set exactly when a < b.
    always_comb begin
        sum = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    end

    assign result = sum[DW-1:0];
    assign carry  = sum[DW];
    assign zero   = (sum[DW-1:0] == '0);
endmodule

// File: rtl/cpu_param.sv
// -----------------------------------------------------------------------------
// cpu_param
// Parametrised accumulator CPU. Fetches from a synchronous RAM (read data is
// captured two edges after the registered read address), executes through
// cpu_param_alu, and talks to the UART through valid/busy handshakes.
// Optional call/return stack is built when CPU_PARAM_STACK_EN is defined;
// otherwise CALL/RET are NOPs and fault is tied low.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         in IDLE: load pc from startaddr and run
//   startaddr     program entry address
//   bus           cpu_param_if.master (RAM ports, UART tx/rx)
//   halted        set by HLT or fault, cleared by start
//   fault         stack over/underflow, cleared by start
// -----------------------------------------------------------------------------
// state     | meaning
// S_IDLE    | stopped, waiting for start
// S_FETCH   | register opcode address, advance pc
// S_WAIT    | RAM access cycle for opcode
// S_OPLOAD  | capture opcode
// S_DECODE  | execute one-byte ops / request operand
// S_WAIT2   | RAM access cycle for operand
// S_OPLOAD2 | capture operand
// S_EXEC2   | execute two-byte ops
// S_WAIT3   | RAM access cycle for LD data
// S_MEMLOAD | capture LD data into register
// S_TX      | wait for UART idle, then transmit
// S_RX      | wait for received byte
// -----------------------------------------------------------------------------
module cpu_param
    import cpu_param_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = 9,
    parameter int NREGS       = 4,
    parameter int STACK_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] startaddr,
    cpu_param_if.master   bus,
    output logic          halted,
    output logic          fault
);
    state_t        state, state_nxt;
    logic [AW-1:0] pc;
    logic          ir_two;
    logic [3:0]    ir_func;
    logic [1:0]    ir_r;
    logic [1:0]    ri;
    logic [DW-1:0] opnd;
    logic [DW-1:0] regs [NREGS];
    logic [1:0]    flags;
    logic [AW-1:0] br_off, br_tgt;
    logic [DW-1:0] alu_res;
    logic          alu_carry, alu_zero;
    logic          ret_err, call_err;

    assign ri     = reg_sel(ir_r, NREGS);
    assign br_off = AW'($signed(opnd));
    assign br_tgt = pc + br_off;

    cpu_param_alu #(.DW(DW)) u_alu (
        .a      (regs[0]),
        .b      (regs[ri]),
        .sub    (ir_func == F_SUB),
        .result (alu_res),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

`ifdef CPU_PARAM_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SAW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0]  stack_mem [2**SAW];
    logic [SPW-1:0] sp;
    logic           fault_q;

    assign ret_err  = (sp == '0);
    assign call_err = (sp == SPW'(STACK_DEPTH));
    assign fault    = fault_q;

    always_ff @(posedge clk) begin
        if (!rst && state == S_EXEC2 && ir_func == F_CALL && !call_err)
            stack_mem[sp[SAW-1:0]] <= pc;
    end
`else
    assign ret_err  = 1'b0;
    assign call_err = 1'b0;
    assign fault    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_WAIT;
            S_WAIT:    state_nxt = S_OPLOAD;
            S_OPLOAD:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (ir_two) begin
                    state_nxt = S_WAIT2;
                end else begin
                    case (ir_func)
                        F_HLT:   state_nxt = S_IDLE;
                        F_OUT:   state_nxt = S_TX;
                        F_IN:    state_nxt = S_RX;
                        F_RET:   state_nxt = ret_err ? S_IDLE : S_FETCH;
                        default: state_nxt = S_FETCH;
                    endcase
                end
            end
            S_WAIT2:   state_nxt = S_OPLOAD2;
            S_OPLOAD2: state_nxt = S_EXEC2;
            S_EXEC2: begin
                if (ir_func == F_LD)                   state_nxt = S_WAIT3;
                else if (ir_func == F_CALL && call_err) state_nxt = S_IDLE;
                else                                   state_nxt = S_FETCH;
            end
            S_WAIT3:   state_nxt = S_MEMLOAD;
            S_MEMLOAD: state_nxt = S_FETCH;
            S_TX:      if (!bus.tx_busy) state_nxt = S_FETCH;
            S_RX:      if (bus.rx_valid) state_nxt = S_FETCH;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= '0;
            ir_two        <= 1'b0;
            ir_func       <= '0;
            ir_r          <= '0;
            opnd          <= '0;
            flags         <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            bus.mem_raddr <= '0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.tx_data   <= '0;
            bus.tx_valid  <= 1'b0;
            halted        <= 1'b0;
`ifdef CPU_PARAM_STACK_EN
            sp            <= '0;
            fault_q       <= 1'b0;
`endif
        end else begin
            bus.mem_we   <= 1'b0;
            bus.tx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc     <= startaddr;
                        halted <= 1'b0;
`ifdef CPU_PARAM_STACK_EN
                        fault_q <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    bus.mem_raddr <= pc;
                    pc            <= pc + 1'b1;
                end
                S_OPLOAD: begin
                    ir_two  <= bus.mem_rdata[OP_TWO_BIT];
                    ir_func <= bus.mem_rdata[6:3];
                    ir_r    <= bus.mem_rdata[1:0];
                end
                S_DECODE: begin
                    if (ir_two) begin
                        bus.mem_raddr <= pc;
                        pc            <= pc + 1'b1;
                    end else begin
                        case (ir_func)
                            F_HLT: halted <= 1'b1;
                            F_ADD, F_SUB: begin
                                regs[0]       <= alu_res;
                                flags[FLAG_Z] <= alu_zero;
                                flags[FLAG_C] <= alu_carry;
                            end
                            F_RET: begin
`ifdef CPU_PARAM_STACK_EN
                                if (ret_err) begin
                                    halted  <= 1'b1;
                                    fault_q <= 1'b1;
                                end else begin
                                    pc <= stack_mem[SAW'(sp - 1'b1)];
                                    sp <= sp - 1'b1;
                                end
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                S_OPLOAD2: opnd <= bus.mem_rdata;
                S_EXEC2: begin
                    case (ir_func)
                        F_LDI: regs[ri] <= opnd;
                        F_LD:  bus.mem_raddr <= AW'(opnd);
                        F_ST: begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_waddr <= AW'(opnd);
                            bus.mem_wdata <= regs[ri];
                        end
                        F_BRA: pc <= br_tgt;
                        F_BRZ: if (flags[FLAG_Z]) pc <= br_tgt;
                        F_BRC: if (flags[FLAG_C]) pc <= br_tgt;
                        F_CALL: begin
`ifdef CPU_PARAM_STACK_EN
                            // pc already points past the operand: that is the return address
                            if (call_err) begin
                                halted  <= 1'b1;
                                fault_q <= 1'b1;
                            end else begin
                                sp <= sp + 1'b1;
                                pc <= br_tgt;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
                S_MEMLOAD: regs[ri] <= bus.mem_rdata;
                S_TX: begin
                    if (!bus.tx_busy) begin
                        bus.tx_data  <= regs[ri];
                        bus.tx_valid <= 1'b1;
                    end
                end
                S_RX: if (bus.rx_valid) regs[ri] <= bus.rx_data;
                default: ;
            endcase
        end
    end
endmodule
